// File: rtl/factor_search.sv
`default_nettype none
// ============================================================================
// Module      : factor_search
// Description : Finds (SEARCH) or checks (CHECK) a nontrivial factorisation
//               target = a * b of a 2W-bit unsigned value.
//               One candidate pair is evaluated per clock cycle.
// Ports       : clk, rst                   - clock, sync active-high reset
//               start, mode                - request, 0=CHECK 1=SEARCH
//               target [2W], in_a/in_b [W] - operands, latched on accept
//               busy, done, found          - status (registered)
//               factor_a/factor_b [W]      - matching pair, else 0
//               eval_count [COUNT_W]       - pairs evaluated, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module factor_search #(
  parameter int W       = 6,
  parameter int COUNT_W = 2 * W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [2*W-1:0]     target,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [W-1:0]       factor_a,
  output logic [W-1:0]       factor_b,
  output logic [COUNT_W-1:0] eval_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0]       ONE_W   = W'(1);
  localparam logic [W-1:0]       TWO_W   = W'(2);
  localparam logic [COUNT_W-1:0] ONE_CNT = COUNT_W'(1);

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [2*W-1:0]       target_q, target_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 found_q, found_d;
  logic [W-1:0]         fa_q, fa_d;
  logic [W-1:0]         fb_q, fb_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;

  logic [2*W-1:0]       prod;
  logic                 is_match;
  logic                 a_max;
  logic                 b_max;
  logic                 over;
  logic                 exhausted;

  // Full-width product: operands zero-extended so nothing is truncated.
  assign prod     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
  assign is_match = (prod == target_q) && (a_q != ONE_W) && (b_q != ONE_W);
  assign a_max    = &a_q;
  assign b_max    = &b_q;
  assign over     = (prod > target_q);
  // With b starting at a for every row, a*a > target is seen exactly at
  // the pair (a,a). The last pair ends the search without incrementing,
  // so the counters never wrap.
  assign exhausted = (over && (a_q == b_q)) || (a_max && b_max);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    target_d = target_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    found_d  = found_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d  = ST_EVAL;
          mode_d   = mode;
          target_d = target;
          a_d      = mode ? TWO_W : in_a;
          b_d      = mode ? TWO_W : in_b;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          found_d  = 1'b0;
          fa_d     = '0;
          fb_d     = '0;
          cnt_d    = '0;
        end
      end

      ST_EVAL: begin
        cnt_d = (&cnt_q) ? cnt_q : (cnt_q + ONE_CNT);
        if (is_match || !mode_q || exhausted) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          if (is_match) begin
            found_d = 1'b1;
            fa_d    = a_q;
            fb_d    = b_q;
          end
        end else if (over || b_max) begin
          a_d = a_q + ONE_W;
          b_d = a_q + ONE_W;
        end else begin
          b_d = b_q + ONE_W;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      target_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      fa_q     <= '0;
      fb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      target_q <= target_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      found_q  <= found_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign found      = found_q;
  assign factor_a   = fa_q;
  assign factor_b   = fb_q;
  assign eval_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_factor_search.sv
`default_nettype none
// ============================================================================
// Module      : tb_factor_search
// Description : Scoreboard bench for factor_search (W=6). The driver pushes
//               the reference result of every accepted request; a monitor
//               pops and compares whenever done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_factor_search;

  localparam int W     = 6;
  localparam int CW    = 2 * W;
  localparam int MAXV  = (1 << W) - 1;
  localparam int LIMIT = 2500;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic [2*W-1:0] target;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          busy;
  logic          done;
  logic          found;
  logic [W-1:0]  factor_a;
  logic [W-1:0]  factor_b;
  logic [CW-1:0] eval_count;

  factor_search #(.W(W), .COUNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .target     (target),
    .in_a       (in_a),
    .in_b       (in_b),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .factor_a   (factor_a),
    .factor_b   (factor_b),
    .eval_count (eval_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit found;
    int fa;
    int fb;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: enumerate pairs in the documented order with plain loops.
  function automatic exp_t model(input bit m, input int t, input int ia, input int ib);
    exp_t r;
    r.found = 0; r.fa = 0; r.fb = 0; r.cnt = 0;
    if (!m) begin
      r.cnt = 1;
      if (ia * ib == t && ia != 1 && ib != 1) begin
        r.found = 1; r.fa = ia; r.fb = ib;
      end
      return r;
    end
    for (int a = 2; a <= MAXV; a++) begin
      if (a * a > t) begin
        r.cnt++;
        return r;
      end
      for (int b = a; b <= MAXV; b++) begin
        r.cnt++;
        if (a * b == t) begin
          r.found = 1; r.fa = a; r.fb = b;
          return r;
        end
        if (a * b > t) break;
      end
    end
    return r;
  endfunction

  // Monitor: counts EVAL cycles and checks each completed operation.
  int busy_run = 0;
  bit done_prev = 0;
  always @(negedge clk) begin
    if (busy) begin
      busy_run++;
      chk("busy_done_overlap", {31'd0, done}, 32'd0);
    end else if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("found",      {31'd0, found},       {31'd0, e.found});
        chk("factor_a",   {26'd0, factor_a},    e.fa);
        chk("factor_b",   {26'd0, factor_b},    e.fb);
        chk("eval_count", {20'd0, eval_count},  e.cnt);
        chk("eval_cycles", busy_run,            e.cnt);
      end
      busy_run = 0;
    end else if (!done) begin
      busy_run = 0;
    end
    done_prev = done;
  end

  task automatic issue(input bit m, input int t, input int ia, input int ib);
    @(negedge clk);
    mode   = m;
    target = t[2*W-1:0];
    in_a   = ia[W-1:0];
    in_b   = ib[W-1:0];
    start  = 1'b1;
    exp_q.push_back(model(m, t, ia, ib));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    chk("done_after_accept", {31'd0, done}, 32'd0);
  endtask

  task automatic wait_done(input bit disturb);
    for (int i = 0; i < LIMIT; i++) begin
      if (done) break;
      @(negedge clk);
      start = 1'b0;
      if (disturb && !done) begin
        mode   = $urandom_range(0, 1);
        target = $urandom_range(0, 4095);
        in_a   = $urandom_range(0, MAXV);
        in_b   = $urandom_range(0, MAXV);
        if (busy && (i % 5 == 2)) start = 1'b1;
      end
    end
    start = 1'b0;
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic op(input bit m, input int t, input int ia, input int ib, input bit disturb);
    issue(m, t, ia, ib);
    wait_done(disturb);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; target = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_done",  {31'd0, done},  32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_fa",    {26'd0, factor_a}, 32'd0);
    chk("rst_fb",    {26'd0, factor_b}, 32'd0);
    chk("rst_cnt",   {20'd0, eval_count}, 32'd0);
    rst = 1'b0;

    // Directed cases
    op(1'b0, 35, 5, 7, 1'b0);
    op(1'b0, 35, 1, 35, 1'b0);
    op(1'b0, 0, 0, 9, 1'b0);
    op(1'b1, 35, 0, 0, 1'b0);
    op(1'b1, 37, 0, 0, 1'b0);
    op(1'b1, 4095, 0, 0, 1'b0);
    op(1'b1, 3969, 0, 0, 1'b0);
    op(1'b1, 0, 0, 0, 1'b0);
    op(1'b1, 35, 0, 0, 1'b1);

    // Abort a search with reset, then an immediate CHECK
    issue(1'b1, 35, 0, 0);
    repeat (8) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_cnt",  {20'd0, eval_count}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    exp_q.delete();
    op(1'b0, 35, 5, 7, 1'b0);

    // Randomized operations
    for (int k = 0; k < 30; k++) begin
      bit m;
      int t, ia, ib;
      m  = $urandom_range(0, 1);
      ia = $urandom_range(0, MAXV);
      ib = $urandom_range(0, MAXV);
      if (k % 7 == 0) ia = 1;
      if (!m) t = ($urandom_range(0, 1) != 0) ? ia * ib : $urandom_range(0, 4095);
      else    t = ($urandom_range(0, 1) != 0) ? $urandom_range(2, 20) * $urandom_range(2, MAXV)
                                              : $urandom_range(0, 1023);
      op(m, t, ia, ib, $urandom_range(0, 1) != 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
